// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator: emits a programmed number of fixed-length frames
// with seed-based payload, optional inter-frame gap and tuser error marking.
module axis_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
  input  logic [15:0]           cfg_frame_count,
  input  logic [7:0]            cfg_gap,
  input  logic                  cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic                  cfg_err_en,
  input  logic [15:0]           cfg_err_index,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  output logic                  busy,
  output logic [15:0]           frames_done
);

  // state   | meaning
  // IDLE    | waiting for cfg_start, outputs quiet
  // SEND    | presenting beats, tvalid high
  // GAP     | idle cycles between frames, tvalid low
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  last_idx_q, last_idx_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [15:0]           count_q, count_d;
  logic [15:0]           frame_q, frame_d;
  logic [15:0]           err_idx_q, err_idx_d;
  logic [15:0]           done_q, done_d;
  logic [7:0]            gap_q, gap_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic                  mode_q, mode_d;
  logic                  err_en_q, err_en_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;
  logic                  busy_q, busy_d;

  logic                  accept;
  logic                  frame_end;
  logic [15:0]           frame_inc;

  // tvalid_q is high exactly when the state register holds SEND
  assign accept    = tvalid_q & output_axis_tready;
  assign frame_end = accept & (beat_q == last_idx_q);
  assign frame_inc = frame_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    beat_d     = beat_q;
    count_d    = count_q;
    frame_d    = frame_q;
    err_idx_d  = err_idx_q;
    done_d     = done_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    mode_d     = mode_q;
    err_en_d   = err_en_q;
    stop_d     = stop_q;
    seed_d     = seed_q;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          // store len-1 so a full-scale length never needs an extra counter bit
          last_idx_d = (cfg_frame_len == '0) ? '0 : cfg_frame_len - LEN_WIDTH'(1);
          count_d    = cfg_frame_count;
          gap_d      = cfg_gap;
          mode_d     = cfg_mode;
          seed_d     = cfg_seed;
          err_en_d   = cfg_err_en;
          err_idx_d  = cfg_err_index;
          beat_d     = '0;
          frame_d    = '0;
          done_d     = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cfg_stop) stop_d = 1'b1;
        if (frame_end) begin
          beat_d  = '0;
          frame_d = frame_inc;
          done_d  = done_q + 16'd1;
          if (((count_q != 16'd0) && (frame_inc == count_q)) || stop_q || cfg_stop) begin
            state_d = ST_IDLE;
          end else if (gap_q == 8'd0) begin
            state_d = ST_SEND;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = gap_q - 8'd1;
          end
        end else if (accept) begin
          beat_d = beat_q + LEN_WIDTH'(1);
        end
      end
      ST_GAP: begin
        if (cfg_stop) begin
          state_d = ST_IDLE;
        end else if (gap_cnt_q == 8'd0) begin
          state_d = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) stop_d = 1'b0;

    // outputs are precomputed from next-state values so they leave flops directly
    tvalid_d = (state_d == ST_SEND);
    busy_d   = (state_d != ST_IDLE);
    tdata_d  = mode_d ? seed_d : seed_d + DATA_WIDTH'(beat_d);
    tlast_d  = tvalid_d && (beat_d == last_idx_d);
    tuser_d  = tlast_d && err_en_d && (frame_d == err_idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_idx_q <= '0;
      beat_q     <= '0;
      count_q    <= '0;
      frame_q    <= '0;
      err_idx_q  <= '0;
      done_q     <= '0;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      mode_q     <= 1'b0;
      err_en_q   <= 1'b0;
      stop_q     <= 1'b0;
      seed_q     <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_idx_q <= last_idx_d;
      beat_q     <= beat_d;
      count_q    <= count_d;
      frame_q    <= frame_d;
      err_idx_q  <= err_idx_d;
      done_q     <= done_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      mode_q     <= mode_d;
      err_en_q   <= err_en_d;
      stop_q     <= stop_d;
      seed_q     <= seed_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      busy_q     <= busy_d;
    end
  end

  assign output_axis_tdata  = tdata_q;
  assign output_axis_tvalid = tvalid_q;
  assign output_axis_tlast  = tlast_q;
  assign output_axis_tuser  = tuser_q;
  assign busy               = busy_q;
  assign frames_done        = done_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: transaction-level reference model,
// directed scenarios with literal expectations, then randomized runs.
`timescale 1ns/1ps
module tb_axis_frame_gen;
  localparam int DW = 8;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_stop = 1'b0;
  logic [LW-1:0] cfg_frame_len = '0;
  logic [15:0]   cfg_frame_count = '0;
  logic [7:0]    cfg_gap = '0;
  logic          cfg_mode = 1'b0;
  logic [DW-1:0] cfg_seed = '0;
  logic          cfg_err_en = 1'b0;
  logic [15:0]   cfg_err_index = '0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic          tuser;
  logic          busy;
  logic [15:0]   frames_done;

  int     errors = 0;
  int     checks = 0;
  int     ready_pct = 100;
  longint cyc = 0;

  axis_frame_gen #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_frame_len(cfg_frame_len), .cfg_frame_count(cfg_frame_count),
    .cfg_gap(cfg_gap), .cfg_mode(cfg_mode), .cfg_seed(cfg_seed),
    .cfg_err_en(cfg_err_en), .cfg_err_index(cfg_err_index),
    .output_axis_tdata(tdata), .output_axis_tvalid(tvalid),
    .output_axis_tready(tready), .output_axis_tlast(tlast),
    .output_axis_tuser(tuser), .busy(busy), .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1 tready = ($urandom_range(0, 99) < ready_pct);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [DW-1:0] data; logic last; logic user; } beat_t;
  beat_t  acc_q[$];
  longint acc_cyc[$];

  bit            m_run, m_start_chk, m_expect_idle, m_gap_open, m_stop, prev_stall;
  int            m_len, m_count, m_gap, m_beat, m_nfr, m_low, last_gap;
  logic [15:0]   m_done, m_err_idx;
  logic          m_mode, m_err_en;
  logic [DW-1:0] m_seed, p_data, exp_data;
  logic          p_last, p_user, exp_last, exp_user;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_run = 0; m_start_chk = 0; m_expect_idle = 0; m_gap_open = 0;
      m_stop = 0; prev_stall = 0; m_done = '0;
    end else begin
      if (m_expect_idle) begin
        chk("end_busy", busy, 0);
        chk("end_tvalid", tvalid, 0);
        m_expect_idle = 0;
        m_run = 0;
      end
      if (m_start_chk) begin
        chk("start_tvalid", tvalid, 1);
        chk("start_busy", busy, 1);
        m_start_chk = 0;
      end
      chk("frames_done", frames_done, m_done);
      if (!m_run) begin
        chk("idle_tvalid", tvalid, 0);
        chk("idle_busy", busy, 0);
      end
      if (prev_stall) begin
        chk("stall_tvalid", tvalid, 1);
        chk("stall_tdata", tdata, p_data);
        chk("stall_tlast", tlast, p_last);
        chk("stall_tuser", tuser, p_user);
      end
      if (m_run) begin
        if (tvalid) begin
          if (m_gap_open) begin
            chk("gap_len", m_low, m_gap);
            last_gap = m_low;
            m_gap_open = 0;
          end
          if (cfg_stop) m_stop = 1;
          if (tready) begin
            exp_data = m_mode ? m_seed : m_seed + DW'(m_beat);
            exp_last = (m_beat == m_len - 1);
            exp_user = exp_last && m_err_en && (16'(m_nfr) == m_err_idx);
            chk("beat_tdata", tdata, exp_data);
            chk("beat_tlast", tlast, exp_last);
            chk("beat_tuser", tuser, exp_user);
            acc_q.push_back(beat_t'({tdata, tlast, tuser}));
            acc_cyc.push_back(cyc);
            if (exp_last) begin
              m_beat = 0;
              m_nfr++;
              m_done = m_done + 16'd1;
              if ((m_count != 0 && m_nfr == m_count) || m_stop) m_expect_idle = 1;
              else begin m_gap_open = 1; m_low = 0; end
            end else begin
              m_beat++;
            end
          end
        end else if (busy) begin
          if (m_gap_open) m_low++;
          if (cfg_stop) begin m_expect_idle = 1; m_gap_open = 0; end
        end else begin
          chk("busy_early_drop", busy, 1);
          m_run = 0;
        end
      end
      prev_stall = tvalid && !tready;
      p_data = tdata; p_last = tlast; p_user = tuser;
      if (!m_run && !busy && cfg_start) begin
        m_len = (cfg_frame_len == '0) ? 1 : int'(cfg_frame_len);
        m_count = int'(cfg_frame_count);
        m_gap = int'(cfg_gap);
        m_mode = cfg_mode; m_seed = cfg_seed;
        m_err_en = cfg_err_en; m_err_idx = cfg_err_index;
        m_beat = 0; m_nfr = 0; m_done = '0; m_stop = 0; m_gap_open = 0;
        m_run = 1; m_start_chk = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run(input int len, input int cnt, input int gap, input bit mode,
                     input logic [DW-1:0] seed, input bit een, input int eidx,
                     input int stop_after, input int budget);
    bit done;
    done = 0;
    acc_q.delete(); acc_cyc.delete();
    @(posedge clk); #1;
    cfg_frame_len = LW'(len); cfg_frame_count = 16'(cnt); cfg_gap = 8'(gap);
    cfg_mode = mode; cfg_seed = seed; cfg_err_en = een; cfg_err_index = 16'(eidx);
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    // later config changes must not reach the running frames
    cfg_frame_len = LW'($urandom); cfg_frame_count = 16'($urandom); cfg_gap = 8'($urandom);
    cfg_mode = ~mode; cfg_seed = DW'($urandom); cfg_err_en = ~een; cfg_err_index = 16'($urandom);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      cfg_start = 1'b0;
      if (!busy) begin done = 1; break; end
      cfg_stop = (stop_after >= 0) && (i == stop_after);
      if (i == 2) cfg_start = 1'b1;
    end
    cfg_stop = 1'b0;
    cfg_start = 1'b0;
    if (!done) chk("run_timeout", 1, 0);
  endtask

  logic [7:0] t1_exp [8] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'hFE, 8'hFF, 8'h00, 8'h01};
  int  nuser, rlen, rcnt, rgap, rstop, reidx;
  bit  found;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frames_done", frames_done, 0);

    // two back-to-back frames, wrapping payload, no bubbles
    ready_pct = 100;
    run(4, 2, 0, 0, 8'hFE, 0, 0, -1, 200);
    chk("t1_beats", acc_q.size(), 8);
    for (int i = 0; i < acc_q.size() && i < 8; i++) begin
      chk("t1_data", acc_q[i].data, t1_exp[i]);
      chk("t1_last", acc_q[i].last, (i == 3 || i == 7));
    end
    if (acc_cyc.size() == 8) chk("t1_no_bubble", acc_cyc[7] - acc_cyc[0], 7);
    chk("t1_frames_done", frames_done, 2);

    // gap with random stalls
    ready_pct = 60; last_gap = -1;
    run(3, 2, 5, 0, 8'h20, 0, 0, -1, 300);
    chk("t2_beats", acc_q.size(), 6);
    chk("t2_gap", last_gap, 5);

    // error marking on third frame only
    ready_pct = 80;
    run(2, 4, 0, 0, 8'h40, 1, 2, -1, 300);
    chk("t3_beats", acc_q.size(), 8);
    nuser = 0;
    for (int i = 0; i < acc_q.size(); i++) begin
      chk("t3_tuser", acc_q[i].user, (i == 5));
      nuser += int'(acc_q[i].user);
    end
    chk("t3_tuser_count", nuser, 1);

    // free-running, stop mid-frame 3 completes that frame
    ready_pct = 100;
    run(5, 0, 0, 0, 8'h10, 0, 0, 10, 200);
    chk("t4_beats", acc_q.size(), 15);
    chk("t4_frames_done", frames_done, 3);
    if (acc_q.size() == 15) chk("t4_last_data", acc_q[14].data, 8'h14);

    // zero length behaves as one beat, constant payload
    run(0, 1, 0, 1, 8'h5A, 0, 0, -1, 50);
    chk("t5_beats", acc_q.size(), 1);
    if (acc_q.size() == 1) begin
      chk("t5_data", acc_q[0].data, 8'h5A);
      chk("t5_last", acc_q[0].last, 1);
    end

    // full-scale frame length
    run(16'hFFFF, 1, 0, 0, 8'h00, 1, 0, -1, 70000);
    chk("t7_beats", acc_q.size(), 65535);
    if (acc_q.size() == 65535) begin
      chk("t7_last_data", acc_q[65534].data, 8'hFE);
      chk("t7_last_flag", acc_q[65534].last, 1);
      chk("t7_last_user", acc_q[65534].user, 1);
    end
    chk("t7_frames_done", frames_done, 1);

    // asynchronous reset on the marked last beat of frame 1
    acc_q.delete();
    @(posedge clk); #1;
    cfg_frame_len = 16'd10; cfg_frame_count = 16'd3; cfg_gap = 8'd0; cfg_mode = 1'b0;
    cfg_seed = 8'h30; cfg_err_en = 1'b1; cfg_err_index = 16'd1; cfg_start = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tvalid && tlast && tuser) begin found = 1; break; end
    end
    chk("t6_reached_marked_last", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_tvalid", tvalid, 0);
    chk("t6_tlast", tlast, 0);
    chk("t6_tuser", tuser, 0);
    chk("t6_busy", busy, 0);
    chk("t6_frames_done", frames_done, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run(10, 1, 0, 0, 8'h30, 0, 0, -1, 100);
    chk("t6_replay_beats", acc_q.size(), 10);
    if (acc_q.size() > 0) chk("t6_replay_first", acc_q[0].data, 8'h30);
    chk("t6_replay_frames", frames_done, 1);

    // randomized runs, all checked by the model
    for (int r = 0; r < 14; r++) begin
      rlen = $urandom_range(0, 6);
      rcnt = $urandom_range(0, 4);
      rgap = $urandom_range(0, 3);
      reidx = $urandom_range(0, 3);
      if (rcnt == 0) rstop = $urandom_range(0, 30);
      else rstop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
      ready_pct = $urandom_range(30, 100);
      run(rlen, rcnt, rgap, 1'($urandom), DW'($urandom), 1'($urandom), reidx, rstop, 400);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
